// File: rtl/note_envelope_fader_if.sv
// Sample bus toward the audio controller: write strobe, allow flag, and the two signed channel samples.
interface note_envelope_fader_if;
  logic               write_audio_out;
  logic               audio_out_allowed;
  logic signed [31:0] left_channel_audio_out;
  logic signed [31:0] right_channel_audio_out;

  modport master (
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out,
    input  audio_out_allowed
  );

  modport slave (
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    output audio_out_allowed
  );
endinterface

// File: rtl/note_envelope_fader.sv
// ADSR envelope over a square tone; samples follow env_level/square_in through 2 register stages.
// Samples hold while audio_out_allowed is low; write strobe = allowed & pipeline valid.
module note_envelope_fader #(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned ATTACK_STEP   = 1311,
  parameter int unsigned DECAY_STEP    = 328,
  parameter int unsigned SUSTAIN_LEVEL = 39321,
  parameter int unsigned RELEASE_STEP  = 131,
  parameter int unsigned PEAK_AMP      = 10000000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  note_on,
  input  logic                  square_in,
  note_envelope_fader_if.master aud,
  output logic [15:0]           env_level,
  output logic                  busy
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        level_q, level_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               note_q;
  logic               busy_q;
  logic [39:0]        prod_q;
  logic               pol_q;
  logic signed [31:0] sample_q, sample_d;
  logic [1:0]         vld_q;

  logic               tick;
  logic [16:0]        att_sum;
  logic [15:0]        att_lvl, dec_lvl, rel_lvl;
  logic [23:0]        mag;
  logic signed [31:0] mag_ext;

  assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);

  // Clamped step results; each compare is done before the subtraction so nothing wraps.
  assign att_sum = {1'b0, level_q} + 17'(ATTACK_STEP);
  assign att_lvl = att_sum[16] ? 16'hFFFF : att_sum[15:0];
  assign dec_lvl = ({1'b0, level_q} < (17'(DECAY_STEP) + 17'(SUSTAIN_LEVEL)))
                 ? 16'(SUSTAIN_LEVEL) : level_q - 16'(DECAY_STEP);
  assign rel_lvl = ({1'b0, level_q} < 17'(RELEASE_STEP))
                 ? 16'd0 : level_q - 16'(RELEASE_STEP);

  // Gate events compare the registered gate with whether the voice is sounding,
  // so a gate change reaches the state register on the second edge.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        level_d = 16'd0;
        if (note_q) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!note_q)                  state_d = ST_RELEASE;
        else if (level_q == 16'hFFFF) state_d = ST_DECAY;
        else if (tick)                level_d = att_lvl;
      end
      ST_DECAY: begin
        if (!note_q)                             state_d = ST_RELEASE;
        else if (level_q <= 16'(SUSTAIN_LEVEL))  state_d = ST_SUSTAIN;
        else if (tick)                           level_d = dec_lvl;
      end
      ST_SUSTAIN: begin
        if (!note_q) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (note_q) begin
          state_d = ST_ATTACK;
        end else if (tick) begin
          if (level_q == 16'd0) state_d = ST_IDLE;
          else                  level_d = rel_lvl;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = 16'd0;
      end
    endcase
  end

  assign mag      = 24'(prod_q >> 16);
  assign mag_ext  = {8'd0, mag};
  assign sample_d = pol_q ? mag_ext : -mag_ext;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      level_q    <= 16'd0;
      tick_cnt_q <= '0;
      note_q     <= 1'b0;
      busy_q     <= 1'b0;
      prod_q     <= 40'd0;
      pol_q      <= 1'b0;
      sample_q   <= 32'sd0;
      vld_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      tick_cnt_q <= tick_cnt_d;
      note_q     <= note_on;
      busy_q     <= (state_q != ST_IDLE);
      prod_q     <= 40'(PEAK_AMP) * 40'(level_q);
      pol_q      <= square_in;
      vld_q      <= {vld_q[0], 1'b1};
      if (aud.audio_out_allowed) sample_q <= sample_d;
    end
  end

  assign aud.write_audio_out         = aud.audio_out_allowed & vld_q[1];
  assign aud.left_channel_audio_out  = sample_q;
  assign aud.right_channel_audio_out = sample_q;
  assign env_level                   = level_q;
  assign busy                        = busy_q;

endmodule

// File: tb/tb_note_envelope_fader.sv
// Randomized bench for note_envelope_fader with an arithmetic model of the envelope level sequences.
module tb_note_envelope_fader;
  localparam int TICK_DIV      = 4;
  localparam int ATTACK_STEP   = 16384;
  localparam int DECAY_STEP    = 8192;
  localparam int SUSTAIN_LEVEL = 32768;
  localparam int RELEASE_STEP  = 16384;
  localparam int PEAK_AMP      = 65536;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        note_on  = 1'b0;
  logic        square_in = 1'b1;
  logic [15:0] env_level;
  logic        busy;

  note_envelope_fader_if aud();

  note_envelope_fader #(
    .TICK_DIV(TICK_DIV), .ATTACK_STEP(ATTACK_STEP), .DECAY_STEP(DECAY_STEP),
    .SUSTAIN_LEVEL(SUSTAIN_LEVEL), .RELEASE_STEP(RELEASE_STEP), .PEAK_AMP(PEAK_AMP)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .note_on(note_on), .square_in(square_in),
    .aud(aud), .env_level(env_level), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  // Expected level sequences straight from the step/clamp rules.
  function automatic void push_rise(int start);
    int l = start;
    while (l < 65535) begin
      l = (l + ATTACK_STEP > 65535) ? 65535 : l + ATTACK_STEP;
      exp_q.push_back(l);
    end
  endfunction

  function automatic void push_fall(int start, int floor_lvl, int stp);
    int l = start;
    while (l > floor_lvl) begin
      l = (l - stp < floor_lvl) ? floor_lvl : l - stp;
      exp_q.push_back(l);
    end
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; note_on = 1'b1; aud.audio_out_allowed = 1'b1;
    square_in = 1'($urandom_range(0, 1));
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (env_level !== 16'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", env_level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (aud.left_channel_audio_out !== 32'sd0) begin n_bad++; $display("FAIL reset_left: got %0d want 0", aud.left_channel_audio_out); end
    n_cmp++; if (aud.right_channel_audio_out !== 32'sd0) begin n_bad++; $display("FAIL reset_right: got %0d want 0", aud.right_channel_audio_out); end
    n_cmp++; if (aud.write_audio_out !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b want 0", aud.write_audio_out); end
    note_on = 1'b0; square_in = 1'b1;
    step();
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    n_cmp++; if (aud.write_audio_out !== 1'b0) begin n_bad++; $display("FAIL write_early: got %b want 0 one cycle after release", aud.write_audio_out); end
    @(negedge CLOCK_50);
    n_cmp++; if (aud.write_audio_out !== 1'b1) begin n_bad++; $display("FAIL write_rise: got %b want 1 two cycles after release", aud.write_audio_out); end
  endtask

  task automatic test_full_note();
    int prev, last_cyc, w;
    exp_q.delete();
    push_rise(0);
    push_fall(65535, SUSTAIN_LEVEL, DECAY_STEP);
    step();
    note_on = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_early: got %b want 0", busy); end
    @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b want 1", busy); end
    prev = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      if (int'(env_level) != prev) begin
        w = exp_q.pop_front();
        n_cmp++; if (env_level !== 16'(w)) begin n_bad++; $display("FAIL adsr_level: got %0d want %0d", env_level, w); end
        if (last_cyc >= 0) begin
          n_cmp++; if (cyc - last_cyc != TICK_DIV) begin n_bad++; $display("FAIL step_spacing: got %0d cycles want %0d", cyc - last_cyc, TICK_DIV); end
        end
        last_cyc = cyc; prev = int'(env_level);
      end
      if (exp_q.size() > 0) @(negedge CLOCK_50);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL adsr_timeout: %0d levels missing want 0", exp_q.size()); end
    repeat ($urandom_range(5, 20)) begin
      @(negedge CLOCK_50);
      n_cmp++; if (env_level !== 16'(SUSTAIN_LEVEL)) begin n_bad++; $display("FAIL sustain_hold: got %0d want %0d", env_level, SUSTAIN_LEVEL); end
    end
  endtask

  task automatic test_release();
    int prev, last_cyc, w, k;
    exp_q.delete();
    push_fall(SUSTAIN_LEVEL, 0, RELEASE_STEP);
    step();
    note_on = 1'b0;
    prev = SUSTAIN_LEVEL; last_cyc = -1;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (int'(env_level) != prev) begin
        w = exp_q.pop_front();
        n_cmp++; if (env_level !== 16'(w)) begin n_bad++; $display("FAIL release_level: got %0d want %0d", env_level, w); end
        if (last_cyc >= 0) begin
          n_cmp++; if (cyc - last_cyc != TICK_DIV) begin n_bad++; $display("FAIL release_spacing: got %0d want %0d", cyc - last_cyc, TICK_DIV); end
        end
        last_cyc = cyc; prev = int'(env_level);
      end
      if (exp_q.size() > 0) @(negedge CLOCK_50);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL release_timeout: %0d levels missing want 0", exp_q.size()); end
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      @(negedge CLOCK_50);
      k++;
    end
    n_cmp++; if (k != TICK_DIV + 1) begin n_bad++; $display("FAIL busy_fall: got %0d cycles want %0d", k, TICK_DIV + 1); end
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (aud.left_channel_audio_out !== 32'sd0 || aud.right_channel_audio_out !== 32'sd0) begin
      n_bad++; $display("FAIL idle_sample: got %0d/%0d want 0", aud.left_channel_audio_out, aud.right_channel_audio_out);
    end
  endtask

  task automatic test_retrigger();
    int prev, w, min_lvl, cyc;
    bit seen;
    step();
    note_on = 1'b1;
    seen = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge CLOCK_50);
      if (env_level == 16'hFFFF) seen = 1;
      if (seen && env_level == 16'(SUSTAIN_LEVEL)) break;
    end
    n_cmp++; if (cyc >= 300) begin n_bad++; $display("FAIL reach_sustain: got %0d cycles want <300", cyc); end
    repeat ($urandom_range(2, 10)) @(negedge CLOCK_50);
    step();
    note_on = 1'b0;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(negedge CLOCK_50);
      if (env_level == 16'(RELEASE_STEP)) break;
    end
    n_cmp++; if (env_level !== 16'(SUSTAIN_LEVEL - RELEASE_STEP)) begin n_bad++; $display("FAIL retrig_start: got %0d want %0d", env_level, SUSTAIN_LEVEL - RELEASE_STEP); end
    note_on = 1'b1;
    exp_q.delete();
    push_rise(SUSTAIN_LEVEL - RELEASE_STEP);
    prev = int'(env_level); min_lvl = prev;
    for (cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (int'(env_level) < min_lvl) min_lvl = int'(env_level);
      if (int'(env_level) != prev) begin
        w = exp_q.pop_front();
        n_cmp++; if (env_level !== 16'(w)) begin n_bad++; $display("FAIL retrig_level: got %0d want %0d", env_level, w); end
        prev = int'(env_level);
      end
      if (exp_q.size() > 0) @(negedge CLOCK_50);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL retrig_timeout: %0d levels missing want 0", exp_q.size()); end
    n_cmp++; if (min_lvl < SUSTAIN_LEVEL - RELEASE_STEP) begin n_bad++; $display("FAIL retrig_dip: got min %0d want >= %0d", min_lvl, SUSTAIN_LEVEL - RELEASE_STEP); end
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge CLOCK_50);
      if (env_level == 16'(SUSTAIN_LEVEL)) break;
    end
    n_cmp++; if (env_level !== 16'(SUSTAIN_LEVEL)) begin n_bad++; $display("FAIL resustain: got %0d want %0d", env_level, SUSTAIN_LEVEL); end
  endtask

  task automatic test_polarity();
    logic signed [31:0] exp_s;
    logic sq_prev;
    square_in = 1'b1; aud.audio_out_allowed = 1'b1;
    repeat (3) step();
    exp_s = 32'sd32768; sq_prev = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge CLOCK_50);
      if (aud.audio_out_allowed) exp_s = sq_prev ? 32'sd32768 : -32'sd32768;
      sq_prev = square_in;
      #1;
      square_in = 1'($urandom_range(0, 1));
      aud.audio_out_allowed = ($urandom_range(0, 3) != 0);
      @(negedge CLOCK_50);
      n_cmp++; if (aud.write_audio_out !== aud.audio_out_allowed) begin n_bad++; $display("FAIL write_strobe: got %b want %b", aud.write_audio_out, aud.audio_out_allowed); end
      n_cmp++; if (aud.left_channel_audio_out !== exp_s) begin n_bad++; $display("FAIL left_sample: got %h want %h", aud.left_channel_audio_out, exp_s); end
      n_cmp++; if (aud.right_channel_audio_out !== exp_s) begin n_bad++; $display("FAIL right_sample: got %h want %h", aud.right_channel_audio_out, exp_s); end
    end
    square_in = 1'b1; aud.audio_out_allowed = 1'b1;
  endtask

  task automatic test_fall_on_tick();
    int cyc;
    step();
    note_on = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge CLOCK_50);
      if (busy == 1'b0) break;
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reach_idle: got busy %b want 0", busy); end
    note_on = 1'b1;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge CLOCK_50);
      if (env_level != 16'd0) break;
    end
    n_cmp++; if (env_level !== 16'(ATTACK_STEP)) begin n_bad++; $display("FAIL first_attack: got %0d want %0d", env_level, ATTACK_STEP); end
    step();
    step();
    note_on = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (env_level !== 16'(ATTACK_STEP)) begin n_bad++; $display("FAIL fall_tick_level: got %0d want %0d", env_level, ATTACK_STEP); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fall_tick_busy: got %b want 1", busy); end
    repeat (TICK_DIV) @(negedge CLOCK_50);
    n_cmp++; if (env_level !== 16'(ATTACK_STEP - RELEASE_STEP)) begin n_bad++; $display("FAIL fall_tick_release: got %0d want %0d", env_level, ATTACK_STEP - RELEASE_STEP); end
  endtask

  task automatic test_async_reset();
    int cyc;
    repeat (12) step();
    note_on = 1'b1;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge CLOCK_50);
      if (env_level != 16'd0) break;
    end
    repeat (3) @(negedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (env_level !== 16'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL async_state: got level %0d busy %b want 0/0", env_level, busy); end
    n_cmp++; if (aud.left_channel_audio_out !== 32'sd0 || aud.write_audio_out !== 1'b0) begin
      n_bad++; $display("FAIL async_out: got sample %0d write %b want 0/0", aud.left_channel_audio_out, aud.write_audio_out);
    end
    note_on = 1'b0;
    step();
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (aud.write_audio_out !== 1'b1) begin n_bad++; $display("FAIL async_rewrite: got %b want 1", aud.write_audio_out); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aud.audio_out_allowed = 1'b1;
    test_reset();
    test_full_note();
    test_release();
    test_retrigger();
    test_polarity();
    test_fall_on_tick();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
